// File: rtl/dma_csr_slave_if.sv
// AXI4-Lite register-port interface (32-bit address and data) with Master/Slave views.
interface AXILiteIntf;
    logic [31:0] AWADDR;
    logic [2:0]  AWPROT;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [31:0] ARADDR;
    logic [2:0]  ARPROT;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;

    modport Slave (
        input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        input  ARADDR, ARPROT, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport Master (
        output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        output ARADDR, ARPROT, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/dma_csr_slave.sv
// AXI4-Lite control/status register block for the DMA engine.
// Define DMA_CSR_SLVERR_EN to answer unmapped and read-only accesses with SLVERR.
module dma_csr_slave #(
    parameter int          ADDR_BITS = 8,
    parameter logic [31:0] ID_VALUE  = 32'hD3A0_0001
) (
    input  logic        ACLK,
    input  logic        ARESET,
    AXILiteIntf.Slave   s_axil,
    output logic        start_o,
    output logic [31:0] src_addr_o,
    output logic [31:0] dst_addr_o,
    output logic [31:0] len_o,
    input  logic        busy_i,
    input  logic        done_i,
    input  logic        err_i,
    output logic        irq_o
);
    localparam int IDX_W = ADDR_BITS - 2;
    localparam logic [IDX_W-1:0] IDX_CTRL   = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_STATUS = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_SRC    = IDX_W'(2);
    localparam logic [IDX_W-1:0] IDX_DST    = IDX_W'(3);
    localparam logic [IDX_W-1:0] IDX_LEN    = IDX_W'(4);
    localparam logic [IDX_W-1:0] IDX_ID     = IDX_W'(5);

    logic             aw_held_reg, w_held_reg, bvalid_reg, rvalid_reg, start_reg;
    logic [IDX_W-1:0] aw_idx_reg;
    logic [31:0]      wdata_reg, rdata_reg;
    logic [3:0]       wstrb_reg;
    logic [1:0]       bresp_reg, rresp_reg;
    logic             irq_en_reg, done_reg, err_reg;
    logic [31:0]      src_reg, dst_reg, len_reg;

    logic             awready, wready, arready, aw_hs, w_hs, ar_hs, commit;
    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic [31:0]      wr_data, wmask, rd_data;
    logic [3:0]       wr_strb;
    logic [1:0]       wr_resp, rd_resp;
    logic             clr_done, clr_err;

    assign awready = !ARESET && !aw_held_reg && !bvalid_reg;
    assign wready  = !ARESET && !w_held_reg && !bvalid_reg;
    assign arready = !ARESET && !rvalid_reg;
    assign aw_hs   = s_axil.AWVALID && awready;
    assign w_hs    = s_axil.WVALID && wready;
    assign ar_hs   = s_axil.ARVALID && arready;

    // Either half may already be parked; the commit happens once both are present.
    assign commit  = (aw_held_reg || aw_hs) && (w_held_reg || w_hs);
    assign wr_idx  = aw_held_reg ? aw_idx_reg : s_axil.AWADDR[ADDR_BITS-1:2];
    assign wr_data = w_held_reg ? wdata_reg : s_axil.WDATA;
    assign wr_strb = w_held_reg ? wstrb_reg : s_axil.WSTRB;
    assign rd_idx  = s_axil.ARADDR[ADDR_BITS-1:2];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_wmask
            assign wmask[gi*8 +: 8] = {8{wr_strb[gi]}};
        end
    endgenerate

    assign clr_done = commit && wr_idx == IDX_STATUS && wr_strb[0] && wr_data[1];
    assign clr_err  = commit && wr_idx == IDX_STATUS && wr_strb[0] && wr_data[2];

    always_comb begin
        wr_resp = 2'b00;
`ifdef DMA_CSR_SLVERR_EN
        if (wr_idx >= IDX_ID || (wr_idx == IDX_STATUS && wr_strb[0] && wr_data[0]))
            wr_resp = 2'b10;
`endif
    end

    always_comb begin
        rd_data = '0;
        rd_resp = 2'b00;
        case (rd_idx)
            IDX_CTRL:   rd_data = {30'd0, irq_en_reg, 1'b0};
            IDX_STATUS: rd_data = {29'd0, err_reg, done_reg, busy_i};
            IDX_SRC:    rd_data = src_reg;
            IDX_DST:    rd_data = dst_reg;
            IDX_LEN:    rd_data = len_reg;
            IDX_ID:     rd_data = ID_VALUE;
            default: begin
                rd_data = '0;
`ifdef DMA_CSR_SLVERR_EN
                rd_resp = 2'b10;
`endif
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_held_reg <= 1'b0;
            w_held_reg  <= 1'b0;
            aw_idx_reg  <= '0;
            wdata_reg   <= '0;
            wstrb_reg   <= '0;
            bvalid_reg  <= 1'b0;
            bresp_reg   <= 2'b00;
            rvalid_reg  <= 1'b0;
            rdata_reg   <= '0;
            rresp_reg   <= 2'b00;
            start_reg   <= 1'b0;
            irq_en_reg  <= 1'b0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
            src_reg     <= '0;
            dst_reg     <= '0;
            len_reg     <= '0;
        end else begin
            if (bvalid_reg && s_axil.BREADY)
                bvalid_reg <= 1'b0;
            if (commit) begin
                aw_held_reg <= 1'b0;
                w_held_reg  <= 1'b0;
                bvalid_reg  <= 1'b1;
                bresp_reg   <= wr_resp;
            end else begin
                if (aw_hs) begin
                    aw_held_reg <= 1'b1;
                    aw_idx_reg  <= s_axil.AWADDR[ADDR_BITS-1:2];
                end
                if (w_hs) begin
                    w_held_reg <= 1'b1;
                    wdata_reg  <= s_axil.WDATA;
                    wstrb_reg  <= s_axil.WSTRB;
                end
            end

            start_reg <= commit && wr_idx == IDX_CTRL && wr_strb[0] && wr_data[0] && !busy_i;
            if (commit && wr_idx == IDX_CTRL && wr_strb[0])
                irq_en_reg <= wr_data[1];
            if (commit && wr_idx == IDX_SRC)
                src_reg <= (src_reg & ~wmask) | (wr_data & wmask);
            if (commit && wr_idx == IDX_DST)
                dst_reg <= (dst_reg & ~wmask) | (wr_data & wmask);
            if (commit && wr_idx == IDX_LEN)
                len_reg <= (len_reg & ~wmask) | (wr_data & wmask);

            // An incoming event outranks a simultaneous W1C.
            done_reg <= done_i || (done_reg && !clr_done);
            err_reg  <= err_i || (err_reg && !clr_err);

            if (ar_hs) begin
                rvalid_reg <= 1'b1;
                rdata_reg  <= rd_data;
                rresp_reg  <= rd_resp;
            end else if (rvalid_reg && s_axil.RREADY) begin
                rvalid_reg <= 1'b0;
            end
        end
    end

    assign s_axil.AWREADY = awready;
    assign s_axil.WREADY  = wready;
    assign s_axil.ARREADY = arready;
    assign s_axil.BVALID  = bvalid_reg;
    assign s_axil.BRESP   = bresp_reg;
    assign s_axil.RVALID  = rvalid_reg;
    assign s_axil.RDATA   = rdata_reg;
    assign s_axil.RRESP   = rresp_reg;

    assign start_o    = start_reg;
    assign src_addr_o = src_reg;
    assign dst_addr_o = dst_reg;
    assign len_o      = len_reg;
    assign irq_o      = irq_en_reg && (done_reg || err_reg);

    logic unused_bits;
    assign unused_bits = &{1'b0, s_axil.AWPROT, s_axil.ARPROT,
                           s_axil.AWADDR[31:ADDR_BITS], s_axil.AWADDR[1:0],
                           s_axil.ARADDR[31:ADDR_BITS], s_axil.ARADDR[1:0]};
endmodule

// File: tb/tb_dma_csr_slave.sv
// Self-checking bench for dma_csr_slave: scoreboarded B/R responses plus per-feature checks.
module tb_dma_csr_slave;
    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        start_o, irq_o;
    logic [31:0] src_addr_o, dst_addr_o, len_o;
    logic        busy_i = 1'b0;
    logic        done_i = 1'b0;
    logic        err_i  = 1'b0;

    AXILiteIntf axil();

    dma_csr_slave dut (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .s_axil     (axil),
        .start_o    (start_o),
        .src_addr_o (src_addr_o),
        .dst_addr_o (dst_addr_o),
        .len_o      (len_o),
        .busy_i     (busy_i),
        .done_i     (done_i),
        .err_i      (err_i),
        .irq_o      (irq_o)
    );

    always #5 ACLK = ~ACLK;

`ifdef DMA_CSR_SLVERR_EN
    localparam logic [1:0] UNMAPPED_RESP = 2'b10;
`else
    localparam logic [1:0] UNMAPPED_RESP = 2'b00;
`endif
    localparam logic [31:0] ID_EXP = 32'hD3A0_0001;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_rdata_q[$];
    logic [1:0]  exp_rresp_q[$];
    logic [1:0]  exp_bresp_q[$];

    // Scoreboard: compare each response on the cycle before it is consumed.
    always @(negedge ACLK) begin
        logic [31:0] ed;
        logic [1:0]  er;
        if (!ARESET && axil.RVALID === 1'b1 && axil.RREADY === 1'b1) begin
            checks++;
            if (exp_rdata_q.size() == 0) begin
                failures++;
                $display("FAIL r_unexpected: got rdata=%h with no read outstanding", axil.RDATA);
            end else begin
                ed = exp_rdata_q.pop_front();
                er = exp_rresp_q.pop_front();
                if ({axil.RDATA, axil.RRESP} !== {ed, er}) begin
                    failures++;
                    $display("FAIL r_resp: got rdata=%h rresp=%b, expected rdata=%h rresp=%b",
                             axil.RDATA, axil.RRESP, ed, er);
                end else
                    $display("read  rdata=%h rresp=%b", axil.RDATA, axil.RRESP);
            end
        end
        if (!ARESET && axil.BVALID === 1'b1 && axil.BREADY === 1'b1) begin
            checks++;
            if (exp_bresp_q.size() == 0) begin
                failures++;
                $display("FAIL b_unexpected: got bresp=%b with no write outstanding", axil.BRESP);
            end else begin
                er = exp_bresp_q.pop_front();
                if (axil.BRESP !== er) begin
                    failures++;
                    $display("FAIL b_resp: got bresp=%b, expected %b", axil.BRESP, er);
                end else
                    $display("write bresp=%b", axil.BRESP);
            end
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp, output bit lat_ok);
        int n;
        n = 0;
        exp_rdata_q.push_back(exp_data);
        exp_rresp_q.push_back(exp_resp);
        axil.RREADY  = 1'b1;
        axil.ARADDR  = addr;
        axil.ARVALID = 1'b1;
        while (axil.ARREADY !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        tick();
        axil.ARVALID = 1'b0;
        lat_ok = (axil.RVALID === 1'b1) && (n < 20);
        tick();
    endtask

    // W is presented w_lead cycles ahead of AW (0 = together).
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int w_lead, input logic [1:0] exp_resp,
                            input bit done_pulse, output bit lat_ok, output int start_cnt);
        exp_bresp_q.push_back(exp_resp);
        axil.BREADY = 1'b1;
        axil.WDATA  = data;
        axil.WSTRB  = strb;
        axil.WVALID = 1'b1;
        for (int i = 0; i < w_lead; i++) begin
            tick();
            axil.WVALID = 1'b0;
        end
        axil.AWADDR  = addr;
        axil.AWVALID = 1'b1;
        done_i = done_pulse;
        tick();
        axil.AWVALID = 1'b0;
        axil.WVALID  = 1'b0;
        done_i = 1'b0;
        lat_ok = (axil.BVALID === 1'b1);
        start_cnt = (start_o === 1'b1) ? 1 : 0;
        tick();
        if (start_o === 1'b1) start_cnt++;
    endtask

    task automatic test_reset();
        ARESET = 1'b1;
        repeat (3) tick();
        checks++;
        if ({axil.AWREADY, axil.WREADY, axil.ARREADY} !== 3'b000) begin
            failures++;
            $display("FAIL reset_ready: got %b, expected 000", {axil.AWREADY, axil.WREADY, axil.ARREADY});
        end
        checks++;
        if ({axil.BVALID, axil.RVALID, start_o, irq_o, axil.BRESP, axil.RRESP, axil.RDATA} !== 38'd0) begin
            failures++;
            $display("FAIL reset_resp: bvalid=%b rvalid=%b start=%b irq=%b bresp=%b rresp=%b rdata=%h, expected all 0",
                     axil.BVALID, axil.RVALID, start_o, irq_o, axil.BRESP, axil.RRESP, axil.RDATA);
        end
        checks++;
        if ({src_addr_o, dst_addr_o, len_o} !== 96'd0) begin
            failures++;
            $display("FAIL reset_regs: src=%h dst=%h len=%h, expected 0", src_addr_o, dst_addr_o, len_o);
        end
        ARESET = 1'b0;
        #1;
        checks++;
        if ({axil.AWREADY, axil.WREADY, axil.ARREADY} !== 3'b111) begin
            failures++;
            $display("FAIL release_ready: got %b, expected 111", {axil.AWREADY, axil.WREADY, axil.ARREADY});
        end
        tick();
    endtask

    task automatic test_id_read();
        bit ok;
        do_read(32'h14, ID_EXP, 2'b00, ok);
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("FAIL id_latency: rvalid not high one cycle after AR");
        end
    endtask

    task automatic test_w_before_aw();
        bit ok;
        int sc;
        do_write(32'h08, 32'h1234_5678, 4'hF, 2, 2'b00, 1'b0, ok, sc);
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("FAIL src_b_latency: bvalid not high after commit");
        end
        checks++;
        if (src_addr_o !== 32'h1234_5678) begin
            failures++;
            $display("FAIL src_value: got %h, expected 12345678", src_addr_o);
        end
        do_read(32'h08, 32'h1234_5678, 2'b00, ok);
    endtask

    task automatic test_strobe();
        bit ok;
        int sc;
        do_write(32'h0C, 32'hAABB_CCDD, 4'b0010, 0, 2'b00, 1'b0, ok, sc);
        checks++;
        if (dst_addr_o !== 32'h0000_CC00) begin
            failures++;
            $display("FAIL dst_strobe: got %h, expected 0000cc00", dst_addr_o);
        end
        do_write(32'h10, 32'hCAFE_F00D, 4'hF, 1, 2'b00, 1'b0, ok, sc);
        checks++;
        if (len_o !== 32'hCAFE_F00D) begin
            failures++;
            $display("FAIL len_value: got %h, expected cafef00d", len_o);
        end
        do_read(32'h10, 32'hCAFE_F00D, 2'b00, ok);
        do_read(32'h0C, 32'h0000_CC00, 2'b00, ok);
    endtask

    task automatic test_start();
        bit ok;
        int sc;
        busy_i = 1'b0;
        do_write(32'h00, 32'h3, 4'hF, 0, 2'b00, 1'b0, ok, sc);
        checks++;
        if (sc !== 1) begin
            failures++;
            $display("FAIL start_pulse: got %0d pulse cycles, expected 1", sc);
        end
        busy_i = 1'b1;
        do_write(32'h00, 32'h3, 4'hF, 0, 2'b00, 1'b0, ok, sc);
        checks++;
        if (sc !== 0) begin
            failures++;
            $display("FAIL start_busy: got %0d pulse cycles, expected 0", sc);
        end
        do_read(32'h00, 32'h2, 2'b00, ok);
        do_read(32'h04, 32'h1, 2'b00, ok);
        busy_i = 1'b0;
    endtask

    task automatic test_done_irq();
        bit ok;
        int sc;
        checks++;
        if (irq_o !== 1'b0) begin
            failures++;
            $display("FAIL irq_idle: got %b, expected 0", irq_o);
        end
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        checks++;
        if (irq_o !== 1'b1) begin
            failures++;
            $display("FAIL irq_done: got %b, expected 1", irq_o);
        end
        do_write(32'h04, 32'h2, 4'hF, 0, 2'b00, 1'b1, ok, sc);
        do_read(32'h04, 32'h2, 2'b00, ok);
        do_write(32'h04, 32'h2, 4'hF, 0, 2'b00, 1'b0, ok, sc);
        checks++;
        if (irq_o !== 1'b0) begin
            failures++;
            $display("FAIL irq_clear: got %b, expected 0", irq_o);
        end
        err_i = 1'b1;
        tick();
        err_i = 1'b0;
        do_read(32'h04, 32'h4, 2'b00, ok);
        checks++;
        if (irq_o !== 1'b1) begin
            failures++;
            $display("FAIL irq_err: got %b, expected 1", irq_o);
        end
        do_write(32'h04, 32'h4, 4'hF, 0, 2'b00, 1'b0, ok, sc);
        do_read(32'h04, 32'h0, 2'b00, ok);
    endtask

    task automatic test_stall_reset();
        int bad;
        bad = 0;
        axil.RREADY  = 1'b0;
        axil.BREADY  = 1'b0;
        axil.ARADDR  = 32'h20;
        axil.ARVALID = 1'b1;
        axil.AWADDR  = 32'h08;
        axil.AWVALID = 1'b1;
        tick();
        axil.ARVALID = 1'b0;
        axil.AWVALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (axil.RVALID !== 1'b1 || axil.RDATA !== 32'd0 || axil.RRESP !== UNMAPPED_RESP) bad++;
            tick();
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL stall_hold: %0d unstable cycles, expected 0 (rresp=%b want %b)",
                     bad, axil.RRESP, UNMAPPED_RESP);
        end
        ARESET = 1'b1;
        tick();
        checks++;
        if (axil.RVALID !== 1'b0) begin
            failures++;
            $display("FAIL reset_abandon: rvalid=%b, expected 0", axil.RVALID);
        end
        ARESET = 1'b0;
        axil.RREADY = 1'b1;
        axil.BREADY = 1'b1;
        #1;
        checks++;
        if ({axil.AWREADY, axil.WREADY, axil.ARREADY} !== 3'b111) begin
            failures++;
            $display("FAIL rerelease_ready: got %b, expected 111", {axil.AWREADY, axil.WREADY, axil.ARREADY});
        end
        axil.WDATA  = 32'hFFFF_FFFF;
        axil.WSTRB  = 4'hF;
        axil.WVALID = 1'b1;
        tick();
        axil.WVALID = 1'b0;
        checks++;
        if (axil.BVALID !== 1'b0 || src_addr_o !== 32'd0) begin
            failures++;
            $display("FAIL stale_aw: bvalid=%b src=%h, expected 0 and 00000000", axil.BVALID, src_addr_o);
        end
        exp_bresp_q.push_back(2'b00);
        axil.AWADDR  = 32'h08;
        axil.AWVALID = 1'b1;
        tick();
        axil.AWVALID = 1'b0;
        checks++;
        if (axil.BVALID !== 1'b1 || src_addr_o !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL late_aw: bvalid=%b src=%h, expected 1 and ffffffff", axil.BVALID, src_addr_o);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        exp_bresp_q.push_back(2'b00);
        exp_rdata_q.push_back(32'hFFFF_FFFF);
        exp_rresp_q.push_back(2'b00);
        axil.AWADDR  = 32'h08;
        axil.WDATA   = 32'h0BAD_BEEF;
        axil.WSTRB   = 4'hF;
        axil.ARADDR  = 32'h08;
        axil.AWVALID = 1'b1;
        axil.WVALID  = 1'b1;
        axil.ARVALID = 1'b1;
        tick();
        axil.AWVALID = 1'b0;
        axil.WVALID  = 1'b0;
        axil.ARVALID = 1'b0;
        checks++;
        if (src_addr_o !== 32'h0BAD_BEEF) begin
            failures++;
            $display("FAIL concurrent_src: got %h, expected 0badbeef", src_addr_o);
        end
        tick();
        tick();
    endtask

    initial begin
        axil.AWADDR = '0; axil.AWPROT = '0; axil.AWVALID = 1'b0;
        axil.WDATA = '0; axil.WSTRB = '0; axil.WVALID = 1'b0; axil.BREADY = 1'b0;
        axil.ARADDR = '0; axil.ARPROT = '0; axil.ARVALID = 1'b0; axil.RREADY = 1'b0;
        test_reset();
        test_id_read();
        test_w_before_aw();
        test_strobe();
        test_start();
        test_done_irq();
        test_stall_reset();
        test_back_to_back();
        checks++;
        if (exp_rdata_q.size() + exp_bresp_q.size() !== 0) begin
            failures++;
            $display("FAIL outstanding: %0d reads and %0d writes never answered, expected 0",
                     exp_rdata_q.size(), exp_bresp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dma_csr_slave.md
# dma_csr_slave

AXI4-Lite slave control/status register block for the DMA engine. It terminates the `AXILiteIntf` Slave modport from the host interconnect and decodes host accesses into a small register map. It drives transfer parameters and a start pulse into the DMA engine, and returns engine status plus an interrupt line.

## Interface
Parameters:
- `ADDR_BITS`, 8: low address bits decoded; bits above are ignored; bits [1:0] are ignored.
- `ID_VALUE`, 32'hD3A0_0001: constant returned by the ID register.

Ports:
- `ACLK`  in  1  single clock for all logic.
- `ARESET`  in  1  synchronous, active-high reset.
- `s_axil`  `AXILiteIntf.Slave`  —  host register port (AW/W/B/AR/R); AWPROT and ARPROT are ignored.
- `start_o`  out  1  one-cycle start pulse to the engine.
- `src_addr_o`  out  32  SRC register.
- `dst_addr_o`  out  32  DST register.
- `len_o`  out  32  LEN register, in bytes.
- `busy_i`  in  1  engine busy level.
- `done_i`  in  1  one-cycle done pulse.
- `err_i`  in  1  one-cycle error pulse.
- `irq_o`  out  1  interrupt, level.

## Operation
Register map (offset, access):
- 0x00 CTRL:
  - bit0 START, write-1 pulse, reads 0.
  - bit1 IRQ_EN, RW.
- 0x04 STATUS:
  - bit0 BUSY, RO, equals `busy_i`.
  - bit1 DONE, W1C.
  - bit2 ERR, W1C.
- 0x08 SRC, RW, 32 bit.
- 0x0C DST, RW, 32 bit.
- 0x10 LEN, RW, 32 bit.
- 0x14 ID, RO, equals `ID_VALUE`.
- Unimplemented register bits read 0.

Write path:
- Flags `aw_held` and `w_held` capture AW and W independently; either may arrive first, or both may arrive together.
- AWREADY = !ARESET & !aw_held & !BVALID. WREADY = !ARESET & !w_held & !BVALID.
- The commit edge is the edge at which the second of AW/W is held (or the edge at which both handshake together). At that edge:
  - the register updates;
  - BVALID is set;
  - both flags clear.
- BVALID holds until BREADY is seen high, then clears.
- WSTRB is honoured per byte on RW registers. START, DONE-clear and ERR-clear require WSTRB[0].
- START=1 with `busy_i`=0 makes `start_o`=1 for exactly the cycle after the commit edge. With `busy_i`=1, START is ignored.
- Writes to RO or unmapped offsets change nothing.

Read path:
- ARREADY = !ARESET & !RVALID.
- On the AR handshake edge, RDATA and RRESP are registered and RVALID is set. RVALID holds until RREADY is seen high.
- If a read and a write to the same register handshake on the same edge, the read returns the pre-write value.

Status and interrupt:
- DONE sets on `done_i`; ERR sets on `err_i`.
- If a set and a W1C clear land in the same cycle, the set wins.
- `irq_o` = IRQ_EN & (DONE | ERR), combinational from register state.

## Timing
- Reset values:
  - all registers 0;
  - BVALID, RVALID, `start_o` 0;
  - BRESP, RRESP, RDATA 0;
  - all READY signals 0 while ARESET is high, and 1 in the first cycle after it is released.
- Write latency: the last of AW/W accepted at edge N → BVALID high in cycle N+1. Register values are visible on the outputs from cycle N+1.
- Read latency: AR accepted at edge N → RVALID high in cycle N+1.
- Maximum throughput is one write per 2 cycles and one read per 2 cycles. Reads and writes proceed concurrently.
- BREADY or RREADY held low stalls the channel indefinitely. Data and responses stay stable while VALID is high.
- ARESET asserted mid-transaction abandons it: no B or R response is issued, and all flags clear.

## Configuration
- `DMA_CSR_SLVERR_EN` defined:
  - accesses to unmapped offsets return BRESP/RRESP = 2'b10 (SLVERR), with RDATA 0;
  - writes to RO registers (STATUS bit0, ID) also return SLVERR, and the writable bits still apply.
- Not defined: every access returns OKAY (2'b00), and unmapped reads return 0.

## Test plan
- Reset, then read 0x14 → RDATA=32'hD3A0_0001, RRESP=OKAY, RVALID one cycle after AR.
- W beat (0x12345678, WSTRB=4'hF) two cycles before AW to 0x08 → single B response OKAY; `src_addr_o`=0x12345678; a read back of 0x08 matches.
- Write 0x0C with WSTRB=4'b0010, data 0xAABBCCDD, over a previous value of 0 → DST=0x0000CC00.
- Write CTRL=0x3 with `busy_i`=0 → `start_o` high for exactly 1 cycle. Repeat with `busy_i`=1 → no pulse, and IRQ_EN stays 1.
- Pulse `done_i` → `irq_o`=1. Write STATUS=0x2 on the same cycle as a second `done_i` pulse → DONE remains 1. A later write of 0x2 → DONE=0 and `irq_o`=0.
- Read 0x20 with BREADY/RREADY held low for 5 cycles → RVALID is held and stable. RRESP=SLVERR with `DMA_CSR_SLVERR_EN` defined, OKAY without. Assert ARESET mid-hold → RVALID=0 the next cycle.
